arb_rr_2x8: RTL and testbench

ARB_RR_2X8 -- requirements
Module: arb_rr_2x8

---
 rtl/arb_rr_2x8.sv | 201 ++++++++++++++++++++
 tb/tb_arb_rr_2x8.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_2x8.sv
// -----------------------------------------------------------------------------
// arb_rr_2x8
//
// Two-lane round-robin arbiter. Each input lane has its own DEPTH-entry FIFO.
// A single registered output stage takes one word per cycle from whichever
// lane has data. When both lanes have data, the grant alternates between them.
//
// Parameters
//   DEPTH  entries per input FIFO (power of two, 2..16)
//   WIDTH  data width of every data port
//
// Ports
//   clk                 single clock, rising edge
//   reset_L             asynchronous active-low reset
//   In0/valid0/ready0   lane-0 input handshake (transfer on valid0 & ready0)
//   In1/valid1/ready1   lane-1 input handshake (transfer on valid1 & ready1)
//   data_out/outValid   registered output word and valid
//   out_ready           downstream accept (transfer on outValid & out_ready)
//   grant_src           lane that supplied the current data_out (registered)
//   grant_cnt0/1        per-lane saturating grant counters
//
// Configuration
//   ARB_GRANT_STATS_EN  when defined, grant_cnt0/1 count pops per lane and
//                       saturate at 16'hFFFF. When undefined, the counters
//                       are absent and both outputs are tied to zero.
// -----------------------------------------------------------------------------
module arb_rr_2x8 #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] In0,
  input  logic             valid0,
  output logic             ready0,
  input  logic [WIDTH-1:0] In1,
  input  logic             valid1,
  output logic             ready1,
  output logic [WIDTH-1:0] data_out,
  output logic             outValid,
  input  logic             out_ready,
  output logic             grant_src,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Per-lane FIFO storage and bookkeeping, indexed by lane number.
  logic [WIDTH-1:0] mem_r [2][DEPTH];
  logic [AW-1:0]    wptr_r [2];
  logic [AW-1:0]    rptr_r [2];
  logic [CW-1:0]    cnt_r  [2];

  logic [WIDTH-1:0] in_s [2];
  logic [1:0]       valid_s;
  logic [1:0]       ready_s;
  logic [1:0]       nonempty_s;
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic             load_s;
  logic [WIDTH-1:0] pop_data_s;

  // Lane that won the most recent pop; the other lane wins the next tie.
  logic             last_grant_r;

  // Lane handshake terms derived from the registered counts only.
  always_comb begin
    in_s[0]    = In0;
    in_s[1]    = In1;
    valid_s    = {valid1, valid0};
    ready_s    = 2'b00;
    nonempty_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready_s[i]    = (cnt_r[i] != CNT_FULL);
      nonempty_s[i] = (cnt_r[i] != CNT_ZERO);
    end
    push_s = valid_s & ready_s;
  end

  assign ready0 = ready_s[0];
  assign ready1 = ready_s[1];

  // Output stage may take a new word when empty or being drained this cycle.
  always_comb begin
    load_s = (!outValid) | out_ready;
  end

  // Round-robin pop selection: a lone non-empty lane always wins; on a tie the
  // lane that did not win last time is popped.
  always_comb begin
    pop_s = 2'b00;
    if (load_s) begin
      case (nonempty_s)
        2'b01:   pop_s = 2'b01;
        2'b10:   pop_s = 2'b10;
        2'b11:   pop_s = last_grant_r ? 2'b01 : 2'b10;
        default: pop_s = 2'b00;
      endcase
    end else begin
      pop_s = 2'b00;
    end
  end

  // Head word of the lane being popped.
  always_comb begin
    if (pop_s[1]) begin
      pop_data_s = mem_r[1][rptr_r[1]];
    end else begin
      pop_data_s = mem_r[0][rptr_r[0]];
    end
  end

  // FIFO storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        mem_r[i][wptr_r[i]] <= in_s[i];
      end
    end
  end

  // FIFO pointers and counts; pointers wrap naturally since DEPTH is 2**AW.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        wptr_r[i] <= PTR_ZERO;
        rptr_r[i] <= PTR_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) begin
          wptr_r[i] <= wptr_r[i] + PTR_ONE;
        end
        if (pop_s[i]) begin
          rptr_r[i] <= rptr_r[i] + PTR_ONE;
        end
        // A simultaneous push and pop leaves the count unchanged.
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_ONE;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Registered output stage and grant history. last_grant resets to lane 1
  // so that lane 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out     <= {WIDTH{1'b0}};
      outValid     <= 1'b0;
      grant_src    <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (load_s) begin
      if (pop_s != 2'b00) begin
        data_out     <= pop_data_s;
        outValid     <= 1'b1;
        grant_src    <= pop_s[1];
        last_grant_r <= pop_s[1];
      end else begin
        // Nothing to send: drop valid, keep the previous word and source.
        outValid     <= 1'b0;
      end
    end
  end

`ifdef ARB_GRANT_STATS_EN
  logic [15:0] gcnt_r [2];

  // Per-lane grant counters, saturating at all-ones.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gcnt_r[0] <= 16'h0000;
      gcnt_r[1] <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pop_s[i] && (gcnt_r[i] != 16'hFFFF)) begin
          gcnt_r[i] <= gcnt_r[i] + 16'h0001;
        end
      end
    end
  end

  assign grant_cnt0 = gcnt_r[0];
  assign grant_cnt1 = gcnt_r[1];
`else
  assign grant_cnt0 = 16'h0000;
  assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_arb_rr_2x8.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_2x8
//
// Self-checking bench for arb_rr_2x8. A queue-based reference model (one
// queue per lane plus a modelled output word) predicts handshakes and outputs
// every cycle. Directed scenarios are followed by a randomized phase with
// occasional mid-stream resets.
// -----------------------------------------------------------------------------
module tb_arb_rr_2x8;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset_L;
  logic [WIDTH-1:0] In0;
  logic             valid0;
  logic             ready0;
  logic [WIDTH-1:0] In1;
  logic             valid1;
  logic             ready1;
  logic [WIDTH-1:0] data_out;
  logic             outValid;
  logic             out_ready;
  logic             grant_src;
  logic [15:0]      grant_cnt0;
  logic [15:0]      grant_cnt1;

  arb_rr_2x8 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .In0        (In0),
    .valid0     (valid0),
    .ready0     (ready0),
    .In1        (In1),
    .valid1     (valid1),
    .ready1     (ready1),
    .data_out   (data_out),
    .outValid   (outValid),
    .out_ready  (out_ready),
    .grant_src  (grant_src),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             m_ov;
  logic [WIDTH-1:0] m_data;
  logic             m_gs;
  logic             m_last;
  int               m_cnt0;
  int               m_cnt1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int c);
`ifdef ARB_GRANT_STATS_EN
    return 16'(c);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_ov   = 1'b0;
    m_data = 8'h00;
    m_gs   = 1'b0;
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // Called at posedge+1: check ready, clock once, update model, check outputs.
  task automatic step();
    logic             a0, a1, ld;
    logic [WIDTH-1:0] d0, d1;
    check_eq("ready0", ready0, (q0.size() != DEPTH));
    check_eq("ready1", ready1, (q1.size() != DEPTH));
    a0 = valid0 && (q0.size() != DEPTH);
    a1 = valid1 && (q1.size() != DEPTH);
    d0 = In0;
    d1 = In1;
    ld = !m_ov || out_ready;
    @(posedge clk);
    if (ld) begin
      if (q0.size() > 0 && (q1.size() == 0 || m_last == 1'b1)) begin
        m_data = q0.pop_front();
        m_ov = 1'b1; m_gs = 1'b0; m_last = 1'b0;
        if (m_cnt0 < 65535) m_cnt0++;
      end else if (q1.size() > 0) begin
        m_data = q1.pop_front();
        m_ov = 1'b1; m_gs = 1'b1; m_last = 1'b1;
        if (m_cnt1 < 65535) m_cnt1++;
      end else begin
        m_ov = 1'b0;
      end
    end
    if (a0) q0.push_back(d0);
    if (a1) q1.push_back(d1);
    #1;
    check_eq("outValid", outValid, m_ov);
    check_eq("data_out", data_out, m_data);
    check_eq("grant_src", grant_src, m_gs);
    check_eq("grant_cnt0", grant_cnt0, exp_cnt(m_cnt0));
    check_eq("grant_cnt1", grant_cnt1, exp_cnt(m_cnt1));
  endtask

  // Asynchronous reset pulse; effect checked before any clock edge.
  task automatic do_reset();
    valid0 = 1'b0;
    valid1 = 1'b0;
    reset_L = 1'b0;
    #1;
    check_eq("rst_outValid", outValid, 1'b0);
    check_eq("rst_ready0", ready0, 1'b1);
    check_eq("rst_ready1", ready1, 1'b1);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_grant_src", grant_src, 1'b0);
    check_eq("rst_cnt0", grant_cnt0, 16'h0000);
    check_eq("rst_cnt1", grant_cnt1, 16'h0000);
    model_clear();
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_seq [8];
  int idx;

  initial begin
    reset_L   = 1'b0;
    In0       = 8'h00;
    In1       = 8'h00;
    valid0    = 1'b0;
    valid1    = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single word on lane 0
    out_ready = 1'b1;
    valid0 = 1'b1; In0 = 8'hA5;
    step();
    valid0 = 1'b0;
    step();
    check_eq("single_valid", outValid, 1'b1);
    check_eq("single_data", data_out, 8'hA5);
    check_eq("single_src", grant_src, 1'b0);
    step();
    check_eq("single_drop", outValid, 1'b0);

    // Preloaded lanes: strict alternation
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid0 = 1'b1; In0 = 8'h10 + 8'(k);
      valid1 = 1'b1; In1 = 8'h20 + 8'(k);
      step();
    end
    valid0 = 1'b0; valid1 = 1'b0;
    exp_seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("alt_valid", outValid, 1'b1);
      check_eq("alt_data", data_out, exp_seq[k]);
      step();
    end
    check_eq("alt_empty", outValid, 1'b0);

    // Lane 1 streams against a stalled output
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      valid1 = (idx < 6);
      In1 = 8'h60 + 8'(idx);
      if (valid1 && q1.size() != DEPTH) idx++;
      step();
    end
    check_eq("stall_ready1", ready1, 1'b0);
    check_eq("stall_accepted", idx, 5);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      valid1 = (idx < 6);
      In1 = 8'h60 + 8'(idx);
      if (valid1 && q1.size() != DEPTH) idx++;
      step();
    end
    valid1 = 1'b0;

    // Full FIFO: pop and refused push in the same cycle
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid0 = 1'b1; In0 = 8'h30 + 8'(k);
      step();
    end
    check_eq("full_ready0", ready0, 1'b0);
    out_ready = 1'b1;
    valid0 = 1'b1; In0 = 8'h99;
    step();
    check_eq("after_pop_ready0", ready0, 1'b1);
    valid0 = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // Reset mid-stream with buffered words
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid1 = 1'b1; In1 = 8'h40 + 8'(k);
      step();
    end
    do_reset();
    out_ready = 1'b1;
    valid0 = 1'b1; In0 = 8'h55;
    step();
    valid0 = 1'b0;
    step();
    check_eq("post_rst_data", data_out, 8'h55);
    check_eq("post_rst_valid", outValid, 1'b1);
    for (int k = 0; k < 4; k++) step();
    check_eq("no_stale", outValid, 1'b0);

    // Grant counters: 5 lane-0 and 3 lane-1 grants
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      valid0 = 1'b1; In0 = 8'h70 + 8'(k);
      valid1 = (k < 3); In1 = 8'h80 + 8'(k);
      step();
    end
    valid0 = 1'b0; valid1 = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("stats_cnt0", grant_cnt0, exp_cnt(5));
    check_eq("stats_cnt1", grant_cnt1, exp_cnt(3));

    // Randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        valid0    = 1'($urandom_range(0, 1));
        valid1    = 1'($urandom_range(0, 1));
        In0       = 8'($urandom);
        In1       = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
